fp_norm_ctrl: RTL and testbench

- Multi-cycle normalization controller for the half-precision floating point datapath.
- Accepts an 11-bit significand (hidden bit at bit 10) and a 5-bit biased exponent over a valid/ready handshake.
- Counts leading zeros, drives one internal `lshifter` instance (11-bit data, 4-bit binary `sel`) and adjusts the exponent.
- Returns the normalized result over a second valid/ready handshake; sits between the adder/multiplier significand stage and the rounding/pack stage.

---
 rtl/fp_norm_ctrl.sv | 146 ++++++++++++++
 tb/tb_fp_norm_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fp_norm_ctrl.sv
// Half-precision normalization controller: leading-zero count, shift and exponent adjust.
// FP_NORM_DENORM_EN selects gradual underflow; undefined flushes to a fully normalized significand.

module lshifter (
    input  logic [10:0] d,
    input  logic [3:0]  sel,
    output logic [10:0] q
);
    assign q = d << sel;
endmodule

module fp_norm_ctrl #(
    parameter int unsigned EW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [10:0]   in_mant,
    input  logic [EW-1:0] in_exp,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [10:0]   out_mant,
    output logic [EW-1:0] out_exp,
    output logic          out_zero,
    output logic          out_uflow,
    output logic          busy
);
    localparam int unsigned MW = 11;
    localparam int unsigned XW = EW + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CNT  = 2'd1;
    localparam logic [1:0] SHF  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    st, st_nx;
    logic [MW-1:0] mant_q;
    logic [EW-1:0] exp_q;
    logic [3:0]    s_q, s_c, lz_c;
    logic [EW-1:0] e_q, e_c;
    logic          uflow_q, uflow_c, zero_q, zero_c;
    logic [MW-1:0] sh_out;
    logic [XW-1:0] e_w, lz_w;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= IDLE;
        else        st <= st_nx;
    end

    // Next-state logic
    always_comb begin
        st_nx = st;
        case (st)
            IDLE:    if (in_valid)  st_nx = CNT;
            CNT:     st_nx = SHF;
            SHF:     st_nx = DONE;
            DONE:    if (out_ready) st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
    end

    assign in_ready  = (st == IDLE);
    assign out_valid = (st == DONE);
    assign busy      = (st != IDLE);

    // Leading-zero count of the held significand; 11 when zero
    always_comb begin
        lz_c = 4'(MW);
        for (int i = 0; i < int'(MW); i++) begin
            if (mant_q[i]) lz_c = 4'(int'(MW) - 1 - i);
        end
    end

    // Shift amount and exponent adjust, in EW+1 bits so nothing wraps
    always_comb begin
        e_w     = {1'b0, exp_q};
        lz_w    = XW'(lz_c);
        s_c     = 4'd0;
        e_c     = '0;
        uflow_c = 1'b0;
        zero_c  = 1'b0;
        if (mant_q == '0) begin
            zero_c = 1'b1;
        end else if (exp_q == '0) begin
            s_c = 4'd0;
        end else if (lz_w <= e_w - XW'(1)) begin
            s_c = lz_c;
            e_c = EW'(e_w - lz_w);
        end else begin
            uflow_c = 1'b1;
`ifdef FP_NORM_DENORM_EN
            s_c = 4'(e_w - XW'(1));
`else
            s_c = lz_c;
`endif
        end
    end

    lshifter u_lshifter (
        .d   (mant_q),
        .sel (s_q),
        .q   (sh_out)
    );

    // Operand capture, shift plan and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mant_q    <= '0;
            exp_q     <= '0;
            s_q       <= '0;
            e_q       <= '0;
            uflow_q   <= 1'b0;
            zero_q    <= 1'b0;
            out_mant  <= '0;
            out_exp   <= '0;
            out_zero  <= 1'b0;
            out_uflow <= 1'b0;
        end else begin
            case (st)
                IDLE: if (in_valid) begin
                    mant_q <= in_mant;
                    exp_q  <= in_exp;
                end
                CNT: begin
                    s_q     <= s_c;
                    e_q     <= e_c;
                    uflow_q <= uflow_c;
                    zero_q  <= zero_c;
                end
                SHF: begin
                    out_mant  <= sh_out;
                    out_exp   <= e_q;
                    out_zero  <= zero_q;
                    out_uflow <= uflow_q;
                end
                DONE: if (out_ready) begin
                    out_zero  <= 1'b0;
                    out_uflow <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_norm_ctrl.sv
// Directed self-checking bench for fp_norm_ctrl; expectations follow FP_NORM_DENORM_EN.

module tb_fp_norm_ctrl;
    logic        clk, rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [10:0] in_mant, out_mant;
    logic [4:0]  in_exp, out_exp;
    logic        out_zero, out_uflow, busy;

    int checks = 0;
    int errors = 0;

    fp_norm_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_zero  (out_zero),
        .out_uflow (out_uflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Full transaction sampled on falling edges; DONE must appear on the third one after accept
    task automatic run_op(input string tag, input logic [10:0] m, input logic [4:0] e,
                          input logic [10:0] em, input logic [4:0] ee,
                          input logic ez, input logic eu);
        @(negedge clk);
        chk({tag, "_in_ready"}, 16'(in_ready), 16'd1);
        in_valid = 1'b1; in_mant = m; in_exp = e;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_cnt_busy"}, 16'(busy), 16'd1);
        @(negedge clk);
        chk({tag, "_shf_valid"}, 16'(out_valid), 16'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 16'(out_valid), 16'd1);
        chk({tag, "_mant"},  16'(out_mant),  16'(em));
        chk({tag, "_exp"},   16'(out_exp),   16'(ee));
        chk({tag, "_zero"},  16'(out_zero),  16'(ez));
        chk({tag, "_uflow"}, 16'(out_uflow), 16'(eu));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle_valid"}, 16'(out_valid), 16'd0);
        chk({tag, "_idle_flags"}, 16'({out_zero, out_uflow}), 16'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_mant = '0; in_exp = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  16'(in_ready),  16'd1);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_busy",      16'(busy),      16'd0);
        chk("rst_mant",      16'(out_mant),  16'd0);
        chk("rst_exp",       16'(out_exp),   16'd0);
        chk("rst_flags",     16'({out_zero, out_uflow}), 16'd0);
        rst_n = 1'b1;

        run_op("normal",    11'h0FF, 5'd10, 11'h7F8, 5'd7,  1'b0, 1'b0);
        run_op("already",   11'h400, 5'd15, 11'h400, 5'd15, 1'b0, 1'b0);
        run_op("zero",      11'h000, 5'd20, 11'h000, 5'd0,  1'b1, 1'b0);
        run_op("subnorm",   11'h0F0, 5'd0,  11'h0F0, 5'd0,  1'b0, 1'b0);
        run_op("lz_eq_em1", 11'h010, 5'd7,  11'h400, 5'd1,  1'b0, 1'b0);
        run_op("lz10",      11'h001, 5'd31, 11'h400, 5'd21, 1'b0, 1'b0);
`ifdef FP_NORM_DENORM_EN
        run_op("uflow",     11'h010, 5'd3,  11'h040, 5'd0,  1'b0, 1'b1);
        run_op("uflow_lze", 11'h010, 5'd6,  11'h200, 5'd0,  1'b0, 1'b1);
`else
        run_op("uflow",     11'h010, 5'd3,  11'h400, 5'd0,  1'b0, 1'b1);
        run_op("uflow_lze", 11'h010, 5'd6,  11'h400, 5'd0,  1'b0, 1'b1);
`endif

        // Backpressure: hold DONE for 10 cycles with a second operand pending
        @(negedge clk);
        in_valid = 1'b1; in_mant = 11'h0FF; in_exp = 5'd10;
        @(negedge clk);
        in_mant = 11'h003; in_exp = 5'd20;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid",    16'(out_valid), 16'd1);
            chk("bp_in_ready", 16'(in_ready),  16'd0);
            chk("bp_mant",     16'(out_mant),  16'h7F8);
            chk("bp_exp",      16'(out_exp),   16'd7);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle_in_ready", 16'(in_ready), 16'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp2_accepted", 16'(busy), 16'd1);
        repeat (2) @(negedge clk);
        chk("bp2_valid", 16'(out_valid), 16'd1);
        chk("bp2_mant",  16'(out_mant),  16'h600);
        chk("bp2_exp",   16'(out_exp),   16'd11);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset asserted while in SHF
        in_valid = 1'b1; in_mant = 11'h0FF; in_exp = 5'd10;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_valid",    16'(out_valid), 16'd0);
        chk("rstmid_busy",     16'(busy),      16'd0);
        chk("rstmid_in_ready", 16'(in_ready),  16'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rstmid_no_stale", 16'({out_valid, busy}), 16'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
